// File: rtl/fifo_reader.sv
// Burst reader: pulls burst_len words from a FIFO read port with one-cycle
// read latency and presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [LEN_WIDTH-1:0]  word_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  count_q, count_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic                  wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0] skid_q [2];

   logic       pop;
   logic       rd_en;
   logic [2:0] level;

   // Outputs are forced quiet while reset is held, even before the first reset edge.
   assign m_valid    = !rd_rst && (occ_q != 2'd0);
   assign pop        = m_valid && m_ready;
   assign level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en      = !rd_rst && (state_q == S_RUN) && !fifo_empty &&
                       (remaining_q != '0) && (level < 3'd2);
   assign fifo_rd_en = rd_en;
   assign busy       = !rd_rst && (state_q != S_IDLE);
   assign done       = !rd_rst && (state_q == S_DONE);
   assign m_data     = m_valid ? skid_q[rd_ptr_q] : '0;
   assign word_count = count_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      len_d       = len_q;
      count_d     = count_q;
      occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
      if (pop && (count_q != len_q))
         count_d = count_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d       = burst_len;
               remaining_d = burst_len;
               count_d     = '0;
               state_d     = (burst_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (rd_en) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == LEN_WIDTH'(1))
                  state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // Last word leaving with nothing behind it in the buffer or the read pipe.
            if (pop && (occ_q == 2'd1) && !inflight_q)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         len_q       <= '0;
         count_q     <= '0;
         occ_q       <= 2'd0;
         inflight_q  <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         len_q       <= len_d;
         count_q     <= count_d;
         occ_q       <= occ_d;
         inflight_q  <= rd_en;
         if (inflight_q)
            wr_ptr_q <= ~wr_ptr_q;
         if (pop)
            rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Storage needs no reset: m_data is masked whenever the buffer is empty.
   always_ff @(posedge rd_clk) begin
      if (!rd_rst && inflight_q)
         skid_q[wr_ptr_q] <= fifo_rd_data;
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a FIFO model with one-cycle read latency
// feeds the DUT; words pushed into it are queued as expected stream output.
module tb_fifo_reader;
   localparam int DW = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rd_rst;
   logic          start;
   logic [LW-1:0] burst_len;
   logic          busy, done, fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_empty;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [LW-1:0] word_count;

   logic [DW-1:0] mem [1024];
   int            wp = 0;
   int            rp = 0;
   logic [DW-1:0] exp_q [$];
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .rd_clk(clk), .rd_rst(rd_rst), .start(start), .burst_len(burst_len),
      .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .word_count(word_count)
   );

   // FIFO model: data for a read issued this cycle appears next cycle.
   assign fifo_empty = (rp == wp);
   always @(posedge clk) begin
      if (fifo_rd_en && (rp < wp)) begin
         fifo_rd_data <= mem[rp];
         rp <= rp + 1;
      end
   end

   task automatic push(input logic [DW-1:0] w);
      mem[wp] = w;
      wp = wp + 1;
      exp_q.push_back(w);
   endtask

   task automatic pulse_start(input logic [LW-1:0] len);
      @(posedge clk); #1;
      start = 1'b1;
      burst_len = len;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rd_rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
      n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rst_m_data: got %h want 00", m_data); end
      @(posedge clk); #1 rd_rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      int nrd = 0, nhs = 0, first_rd = -1, last_rd = -1, first_hs = -1, last_hs = -1, done_c = -1;
      logic [DW-1:0] ev;
      push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
      m_ready = 1'b1;
      pulse_start(8'd4);
      for (int c = 0; c < 40 && done_c < 0; c++) begin
         @(negedge clk);
         if (fifo_rd_en) begin nrd++; if (first_rd < 0) first_rd = c; last_rd = c; end
         if (m_valid && m_ready) begin
            nhs++; if (first_hs < 0) first_hs = c; last_hs = c;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (m_data !== ev) begin n_bad++; $display("FAIL basic_data: got %h want %h", m_data, ev); end
         end
         if (done) done_c = c;
      end
      n_cmp++; if (done_c < 0) begin n_bad++; $display("FAIL basic_timeout: done not seen within 40 cycles"); end
      n_cmp++; if (nrd !== 4 || last_rd - first_rd !== 3) begin n_bad++; $display("FAIL basic_reads: got %0d over %0d cycles want 4 over 4", nrd, last_rd - first_rd + 1); end
      n_cmp++; if (first_rd !== 0) begin n_bad++; $display("FAIL basic_first_read: got cycle %0d want 0", first_rd); end
      n_cmp++; if (first_hs !== 2) begin n_bad++; $display("FAIL basic_latency: got cycle %0d want 2", first_hs); end
      n_cmp++; if (nhs !== 4 || last_hs - first_hs !== 3) begin n_bad++; $display("FAIL basic_handshakes: got %0d over %0d cycles want 4 over 4", nhs, last_hs - first_hs + 1); end
      n_cmp++; if (done_c !== last_hs + 1) begin n_bad++; $display("FAIL basic_done_timing: got cycle %0d want %0d", done_c, last_hs + 1); end
      n_cmp++; if (word_count !== 8'd4) begin n_bad++; $display("FAIL basic_word_count: got %0d want 4", word_count); end
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || word_count !== 8'd4) begin n_bad++; $display("FAIL basic_idle_hold: got busy %b count %0d want 0 4", busy, word_count); end
   endtask

   task automatic test_stall();
      int nrd = 0, stall_rd = 0, nhs = 0;
      bit seen_v = 0, fin = 0, stable = 1;
      logic [DW-1:0] ev;
      push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
      m_ready = 1'b0;
      pulse_start(8'd4);
      for (int c = 0; c < 10 && !seen_v; c++) begin
         @(negedge clk);
         if (fifo_rd_en) nrd++;
         seen_v = m_valid;
      end
      n_cmp++; if (!seen_v) begin n_bad++; $display("FAIL stall_valid_timeout: m_valid not seen within 10 cycles"); end
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         if (fifo_rd_en) nrd++;
         if (!m_valid || m_data !== 8'hA1) stable = 0;
      end
      stall_rd = nrd;
      n_cmp++; if (stall_rd > 2) begin n_bad++; $display("FAIL stall_reads: got %0d want <= 2", stall_rd); end
      n_cmp++; if (!stable) begin n_bad++; $display("FAIL stall_hold: got data %h valid %b want A1 1", m_data, m_valid); end
      @(posedge clk); #1 m_ready = 1'b1;
      for (int c = 0; c < 30 && !fin; c++) begin
         @(negedge clk);
         if (fifo_rd_en) nrd++;
         if (m_valid && m_ready) begin
            nhs++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (m_data !== ev) begin n_bad++; $display("FAIL stall_data: got %h want %h", m_data, ev); end
         end
         if (done) fin = 1;
      end
      n_cmp++; if (!fin) begin n_bad++; $display("FAIL stall_timeout: done not seen"); end
      n_cmp++; if (nrd !== 4 || nhs !== 4) begin n_bad++; $display("FAIL stall_counts: got %0d reads %0d hs want 4 4", nrd, nhs); end
      n_cmp++; if (word_count !== 8'd4) begin n_bad++; $display("FAIL stall_word_count: got %0d want 4", word_count); end
   endtask

   task automatic test_empty_stall();
      int nrd = 0, nhs = 0;
      bit fin = 0, busy_ok = 1, no_bad_rd = 1;
      logic [DW-1:0] ev;
      push(8'h11); push(8'h22);
      m_ready = 1'b1;
      pulse_start(8'd4);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (fifo_rd_en) nrd++;
         if (fifo_rd_en && fifo_empty) no_bad_rd = 0;
         if (!busy) busy_ok = 0;
         if (m_valid && m_ready) begin
            nhs++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (m_data !== ev) begin n_bad++; $display("FAIL empty_data: got %h want %h", m_data, ev); end
         end
      end
      n_cmp++; if (nrd !== 2) begin n_bad++; $display("FAIL empty_reads_stalled: got %0d want 2", nrd); end
      n_cmp++; if (!busy_ok) begin n_bad++; $display("FAIL empty_busy: got 0 want 1"); end
      @(posedge clk); #1;
      push(8'h33); push(8'h44);
      for (int c = 0; c < 20 && !fin; c++) begin
         @(negedge clk);
         if (fifo_rd_en) nrd++;
         if (fifo_rd_en && fifo_empty) no_bad_rd = 0;
         if (m_valid && m_ready) begin
            nhs++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (m_data !== ev) begin n_bad++; $display("FAIL empty_data: got %h want %h", m_data, ev); end
         end
         if (done) fin = 1;
      end
      n_cmp++; if (!fin) begin n_bad++; $display("FAIL empty_timeout: done not seen"); end
      n_cmp++; if (!no_bad_rd) begin n_bad++; $display("FAIL empty_read_while_empty: got read want none"); end
      n_cmp++; if (nrd !== 4 || nhs !== 4) begin n_bad++; $display("FAIL empty_counts: got %0d reads %0d hs want 4 4", nrd, nhs); end
   endtask

   task automatic test_zero_len();
      int done_at = -1, ndone = 0;
      bit quiet = 1;
      m_ready = 1'b1;
      pulse_start(8'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) begin ndone++; if (done_at < 0) done_at = c; end
         if (fifo_rd_en || m_valid) quiet = 0;
      end
      n_cmp++; if (done_at !== 0 || ndone !== 1) begin n_bad++; $display("FAIL zero_done: got cycle %0d count %0d want 0 1", done_at, ndone); end
      n_cmp++; if (!quiet) begin n_bad++; $display("FAIL zero_quiet: got activity want none"); end
      n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL zero_word_count: got %0d want 0", word_count); end
   endtask

   task automatic test_reset_mid();
      int nhs = 0, drop;
      bit fin = 0;
      logic [DW-1:0] ev;
      push(8'h51); push(8'h52); push(8'h53); push(8'h54); push(8'h55); push(8'h56);
      m_ready = 1'b1;
      pulse_start(8'd4);
      for (int c = 0; c < 10 && nhs < 2; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            nhs++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (m_data !== ev) begin n_bad++; $display("FAIL rmid_data: got %h want %h", m_data, ev); end
         end
      end
      @(posedge clk); #1 rd_rst = 1'b1;
      // Words already pulled from the FIFO are lost with the reset.
      drop = exp_q.size() - (wp - rp);
      repeat (drop) void'(exp_q.pop_front());
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rmid_during: got busy %b valid %b rd %b want 0 0 0", busy, m_valid, fifo_rd_en); end
      @(posedge clk); #1 rd_rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_after: got busy %b valid %b want 0 0", busy, m_valid); end
      n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL rmid_word_count: got %0d want 0", word_count); end
      nhs = 0;
      pulse_start(8'd2);
      for (int c = 0; c < 20 && !fin; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            nhs++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (m_data !== ev) begin n_bad++; $display("FAIL rmid_new_data: got %h want %h", m_data, ev); end
         end
         if (done) fin = 1;
      end
      n_cmp++; if (!fin || nhs !== 2) begin n_bad++; $display("FAIL rmid_new_burst: got done %b hs %0d want 1 2", fin, nhs); end
      n_cmp++; if (word_count !== 8'd2 || exp_q.size() !== 0) begin n_bad++; $display("FAIL rmid_final: got count %0d left %0d want 2 0", word_count, exp_q.size()); end
   endtask

   task automatic test_restart_ignored();
      int nrd = 0, nhs = 0;
      bit fin = 0;
      logic [DW-1:0] ev;
      push(8'h61); push(8'h62); push(8'h63); push(8'h64);
      m_ready = 1'b1;
      pulse_start(8'd4);
      for (int c = 0; c < 30 && !fin; c++) begin
         @(negedge clk);
         if (fifo_rd_en) nrd++;
         if (m_valid && m_ready) begin
            nhs++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (m_data !== ev) begin n_bad++; $display("FAIL restart_data: got %h want %h", m_data, ev); end
         end
         if (done) fin = 1;
         @(posedge clk); #1;
         start = (c == 1);
         burst_len = (c == 1) ? 8'd7 : 8'd0;
      end
      start = 1'b0;
      n_cmp++; if (!fin) begin n_bad++; $display("FAIL restart_timeout: done not seen"); end
      n_cmp++; if (nrd !== 4 || nhs !== 4 || word_count !== 8'd4) begin n_bad++; $display("FAIL restart_counts: got %0d reads %0d hs count %0d want 4 4 4", nrd, nhs, word_count); end
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL restart_idle: got busy %b want 0", busy); end
   endtask

   task automatic test_max_len();
      int nrd = 0, nhs = 0;
      bit fin = 0;
      logic [DW-1:0] ev;
      for (int i = 0; i < 255; i++) push(DW'($urandom));
      m_ready = 1'b1;
      pulse_start(8'd255);
      for (int c = 0; c < 3000 && !fin; c++) begin
         @(negedge clk);
         if (fifo_rd_en) nrd++;
         if (m_valid && m_ready) begin
            nhs++;
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_cmp++; if (m_data !== ev) begin n_bad++; $display("FAIL max_data: got %h want %h at hs %0d", m_data, ev, nhs); end
         end
         if (done) fin = 1;
         @(posedge clk); #1 m_ready = ($urandom_range(0, 3) != 0);
      end
      m_ready = 1'b1;
      n_cmp++; if (!fin) begin n_bad++; $display("FAIL max_timeout: done not seen"); end
      n_cmp++; if (nrd !== 255 || nhs !== 255) begin n_bad++; $display("FAIL max_counts: got %0d reads %0d hs want 255 255", nrd, nhs); end
      n_cmp++; if (word_count !== 8'd255) begin n_bad++; $display("FAIL max_word_count: got %0d want 255", word_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_empty_stall();
      test_zero_len();
      test_reset_mid();
      test_restart_ignored();
      test_max_len();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
